// File: rtl/msf_symbol_sampler_if.sv
// Receiver-side signal bundle for the MSF symbol sampler.
// The master drives the demodulated carrier; the slave returns one decoded symbol per second.
interface msf_symbol_sampler_if;
  logic data_i;
  logic sync_o;
  logic bit_a_o;
  logic bit_b_o;
  logic minute_o;
  logic valid_o;
  logic error_o;

  modport master (
    output data_i,
    input  sync_o, bit_a_o, bit_b_o, minute_o, valid_o, error_o
  );

  modport slave (
    input  data_i,
    output sync_o, bit_a_o, bit_b_o, minute_o, valid_o, error_o
  );
endinterface

// File: rtl/msf_symbol_sampler.sv
// MSF second decoder: synchronises and debounces the carrier, then locks to second-start edges.
// Bits A and B and the minute marker are voted over guarded ms windows, and framing faults are flagged.
module msf_symbol_sampler #(
  parameter int unsigned CLK_FREQ    = 1000,
  parameter int unsigned DEBOUNCE_MS = 3,
  parameter int unsigned GUARD_MS    = 20,
  parameter int unsigned ARM_MS      = 500
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  msf_symbol_sampler_if.slave  bus
);

  localparam int unsigned DIV    = CLK_FREQ / 1000;
  localparam int unsigned DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned MS_W   = 11;
  localparam int unsigned DEB_W  = 4;
  localparam int unsigned ARM_W  = $clog2(ARM_MS + 1);
  localparam int unsigned VOTE_W = 8;
  localparam int unsigned VW1    = VOTE_W + 1;
  localparam int unsigned A_LO   = 100 + GUARD_MS;
  localparam int unsigned A_HI   = 200 - GUARD_MS;
  localparam int unsigned B_LO   = 200 + GUARD_MS;
  localparam int unsigned B_HI   = 300 - GUARD_MS;
  localparam int unsigned M_LO   = 300 + GUARD_MS;
  localparam int unsigned M_HI   = 500 - GUARD_MS;
  localparam int unsigned A_LEN  = A_HI - A_LO;
  localparam int unsigned B_LEN  = B_HI - B_LO;
  localparam int unsigned M_LEN  = M_HI - M_LO;

  typedef enum logic [1:0] {IDLE, WAIT_EDGE, MEASURE, TAIL} state_t;

  state_t              state_q;
  logic                sync1_q, sync2_q;
  logic [DIV_W-1:0]    div_q;
  logic                filt_q, filt_d;
  logic [DEB_W-1:0]    deb_q, deb_d;
  logic [MS_W-1:0]     ms_q;
  logic [ARM_W-1:0]    arm_q;
  logic [VOTE_W-1:0]   cnt_a_q, cnt_b_q, cnt_m_q;
  logic                sync_q, bit_a_q, bit_b_q, minute_q, valid_q, error_q;

  logic                tick_c, off_edge_c, on_edge_c;
  logic                in_a_c, in_b_c, in_m_c;
  logic                vote_a_c, vote_b_c, vote_m_c;
  logic [MS_W-1:0]     ms_inc_c;

  assign tick_c = (div_q == DIV_W'(DIV - 1));

  // Filtered level flips only after DEBOUNCE_MS consecutive disagreeing ticks
  always_comb begin
    filt_d = filt_q;
    deb_d  = deb_q;
    if (tick_c) begin
      if (sync2_q != filt_q) begin
        if (deb_q == DEB_W'(DEBOUNCE_MS - 1)) begin
          filt_d = ~filt_q;
          deb_d  = '0;
        end else begin
          deb_d = deb_q + DEB_W'(1);
        end
      end else begin
        deb_d = '0;
      end
    end
  end

  assign off_edge_c = ~filt_q & filt_d;
  assign on_edge_c  = filt_q & ~filt_d;
  assign ms_inc_c   = (ms_q == MS_W'(2047)) ? ms_q : ms_q + MS_W'(1);

  assign in_a_c = (ms_q >= MS_W'(A_LO)) && (ms_q < MS_W'(A_HI));
  assign in_b_c = (ms_q >= MS_W'(B_LO)) && (ms_q < MS_W'(B_HI));
  assign in_m_c = (ms_q >= MS_W'(M_LO)) && (ms_q < MS_W'(M_HI));

  assign vote_a_c = ({cnt_a_q, 1'b0} > VW1'(A_LEN));
  assign vote_b_c = ({cnt_b_q, 1'b0} > VW1'(B_LEN));
  assign vote_m_c = ({cnt_m_q, 1'b0} > VW1'(M_LEN));

  // Edge handling is placed after the tick increment so an edge reloads ms_q to 0
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      div_q    <= '0;
      filt_q   <= 1'b0;
      deb_q    <= '0;
      ms_q     <= '0;
      arm_q    <= '0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      cnt_m_q  <= '0;
      sync_q   <= 1'b0;
      bit_a_q  <= 1'b0;
      bit_b_q  <= 1'b0;
      minute_q <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
    end else begin
      sync1_q <= bus.data_i;
      sync2_q <= sync1_q;
      div_q   <= tick_c ? '0 : div_q + DIV_W'(1);
      filt_q  <= filt_d;
      deb_q   <= deb_d;
      sync_q  <= 1'b0;
      valid_q <= 1'b0;
      error_q <= 1'b0;
      if (tick_c) ms_q <= ms_inc_c;

      case (state_q)
        IDLE: begin
          if (tick_c) begin
            if (filt_q) begin
              arm_q <= '0;
            end else if (arm_q == ARM_W'(ARM_MS - 1)) begin
              arm_q   <= '0;
              state_q <= WAIT_EDGE;
            end else begin
              arm_q <= arm_q + ARM_W'(1);
            end
          end
        end
        WAIT_EDGE: begin
          if (off_edge_c) begin
            sync_q  <= 1'b1;
            ms_q    <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            cnt_m_q <= '0;
            state_q <= MEASURE;
          end
        end
        MEASURE: begin
          if (tick_c) begin
            if (on_edge_c && (ms_q < MS_W'(80))) begin
              error_q <= 1'b1;
              state_q <= WAIT_EDGE;
            end else if (ms_q == MS_W'(520)) begin
              bit_a_q  <= vote_a_c;
              bit_b_q  <= vote_b_c;
              minute_q <= vote_m_c;
              valid_q  <= 1'b1;
              state_q  <= TAIL;
            end else if (filt_q) begin
              if (in_a_c) cnt_a_q <= cnt_a_q + VOTE_W'(1);
              if (in_b_c) cnt_b_q <= cnt_b_q + VOTE_W'(1);
              if (in_m_c) cnt_m_q <= cnt_m_q + VOTE_W'(1);
            end
          end
        end
        TAIL: begin
          if (off_edge_c) begin
            sync_q  <= 1'b1;
            error_q <= (ms_q < MS_W'(900));
            ms_q    <= '0;
            cnt_a_q <= '0;
            cnt_b_q <= '0;
            cnt_m_q <= '0;
            state_q <= MEASURE;
          end else if (tick_c && (ms_q == MS_W'(1999))) begin
            error_q <= 1'b1;
            arm_q   <= '0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.sync_o   = sync_q;
  assign bus.bit_a_o  = bit_a_q;
  assign bus.bit_b_o  = bit_b_q;
  assign bus.minute_o = minute_q;
  assign bus.valid_o  = valid_q;
  assign bus.error_o  = error_q;

endmodule

// File: tb/tb_msf_symbol_sampler.sv
// Bench for msf_symbol_sampler at 1 ms per cycle: decoded symbols are checked against a queue of
// expected {a,b,minute} values, and sync/error/valid pulse counts are checked per scenario.
module tb_msf_symbol_sampler;

  logic clk_i;
  logic rst_i;

  msf_symbol_sampler_if bus();

  msf_symbol_sampler #(
    .CLK_FREQ(1000), .DEBOUNCE_MS(3), .GUARD_MS(20), .ARM_MS(500)
  ) dut (
    .clk_i(clk_i),
    .rst_i(rst_i),
    .bus  (bus)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int sync_n = 0, err_n = 0, valid_n = 0, both_n = 0;
  int last_sync_cyc = 0, last_valid_cyc = 0;
  logic [2:0] exp_q[$];

  // One clock step: sample at the falling edge and score any emitted symbol
  task automatic step();
    logic [2:0] want;
    @(negedge clk_i);
    cyc++;
    if (bus.sync_o)  begin sync_n++; last_sync_cyc = cyc; end
    if (bus.error_o) err_n++;
    if (bus.sync_o && bus.error_o) both_n++;
    if (bus.valid_o) begin
      valid_n++;
      last_valid_cyc = cyc;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL symbol_unexpected: got abm=%b%b%b at cycle %0d, none expected",
                 bus.bit_a_o, bus.bit_b_o, bus.minute_o, cyc);
      end else begin
        want = exp_q.pop_front();
        if ({bus.bit_a_o, bus.bit_b_o, bus.minute_o} !== want) begin
          errors++;
          $display("FAIL symbol: got abm=%b%b%b expected %b at cycle %0d",
                   bus.bit_a_o, bus.bit_b_o, bus.minute_o, want, cyc);
        end
      end
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      bus.data_i = lvl;
      step();
    end
  endtask

  task automatic second(input int off_ms, input logic [2:0] want);
    exp_q.push_back(want);
    drive(1'b1, off_ms);
    drive(1'b0, 1000 - off_ms);
  endtask

  task automatic test_reset();
    rst_i = 1'b1;
    bus.data_i = 1'b0;
    repeat (4) step();
    checks++;
    if ({bus.sync_o, bus.bit_a_o, bus.bit_b_o, bus.minute_o, bus.valid_o, bus.error_o} !== 6'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b%b%b%b%b%b expected 000000", bus.sync_o, bus.bit_a_o,
               bus.bit_b_o, bus.minute_o, bus.valid_o, bus.error_o);
    end
    rst_i = 1'b0;
    drive(1'b0, 600);
    checks++;
    if (sync_n !== 0) begin
      errors++;
      $display("FAIL arm_no_sync: got %0d sync pulses expected 0", sync_n);
    end
  endtask

  task automatic test_basic();
    int s0 = sync_n, e0 = err_n, v0 = valid_n;
    second(100, 3'b000);
    checks++;
    if (sync_n - s0 !== 1) begin errors++; $display("FAIL basic_sync: got %0d expected 1", sync_n - s0); end
    checks++;
    if (valid_n - v0 !== 1) begin errors++; $display("FAIL basic_valid: got %0d expected 1", valid_n - v0); end
    checks++;
    if (err_n - e0 !== 0) begin errors++; $display("FAIL basic_error: got %0d expected 0", err_n - e0); end
    checks++;
    if ((last_valid_cyc - last_sync_cyc < 519) || (last_valid_cyc - last_sync_cyc > 521)) begin
      errors++;
      $display("FAIL basic_latency: got %0d cycles expected 520", last_valid_cyc - last_sync_cyc);
    end
  endtask

  task automatic test_bits();
    int s0 = sync_n, e0 = err_n, v0 = valid_n;
    second(200, 3'b100);
    exp_q.push_back(3'b010);
    drive(1'b1, 100); drive(1'b0, 100); drive(1'b1, 100); drive(1'b0, 700);
    second(300, 3'b110);
    checks++;
    if (valid_n - v0 !== 3) begin errors++; $display("FAIL bits_valid: got %0d expected 3", valid_n - v0); end
    checks++;
    if (sync_n - s0 !== 3) begin errors++; $display("FAIL bits_sync: got %0d expected 3", sync_n - s0); end
    checks++;
    if (err_n - e0 !== 0) begin errors++; $display("FAIL bits_error: got %0d expected 0", err_n - e0); end
  endtask

  task automatic test_minute();
    int v0 = valid_n;
    second(500, 3'b111);
    second(100, 3'b000);
    checks++;
    if (valid_n - v0 !== 2) begin errors++; $display("FAIL minute_valid: got %0d expected 2", valid_n - v0); end
  endtask

  task automatic test_glitch();
    int s0 = sync_n, e0 = err_n, v0 = valid_n;
    exp_q.push_back(3'b100);
    drive(1'b1, 50); drive(1'b0, 2); drive(1'b1, 98); drive(1'b0, 2); drive(1'b1, 48);
    drive(1'b0, 400); drive(1'b1, 2); drive(1'b0, 398);
    checks++;
    if (sync_n - s0 !== 1) begin errors++; $display("FAIL glitch_sync: got %0d expected 1", sync_n - s0); end
    checks++;
    if (err_n - e0 !== 0) begin errors++; $display("FAIL glitch_error: got %0d expected 0", err_n - e0); end
    checks++;
    if (valid_n - v0 !== 1) begin errors++; $display("FAIL glitch_valid: got %0d expected 1", valid_n - v0); end
  endtask

  task automatic test_framing();
    int s0 = sync_n, e0 = err_n, v0 = valid_n, b0 = both_n;
    // short start pulse
    drive(1'b1, 50); drive(1'b0, 950);
    checks++;
    if (err_n - e0 !== 1) begin errors++; $display("FAIL short_error: got %0d expected 1", err_n - e0); end
    checks++;
    if (valid_n - v0 !== 0) begin errors++; $display("FAIL short_valid: got %0d expected 0", valid_n - v0); end
    checks++;
    if ({bus.bit_a_o, bus.bit_b_o, bus.minute_o} !== 3'b100) begin
      errors++;
      $display("FAIL short_held: got %b%b%b expected 100", bus.bit_a_o, bus.bit_b_o, bus.minute_o);
    end
    // early edge at ms 700 of the TAIL
    s0 = sync_n; e0 = err_n; v0 = valid_n;
    exp_q.push_back(3'b000);
    drive(1'b1, 100); drive(1'b0, 600);
    second(200, 3'b100);
    checks++;
    if (both_n - b0 !== 1) begin errors++; $display("FAIL early_sync_err: got %0d expected 1", both_n - b0); end
    checks++;
    if (sync_n - s0 !== 2) begin errors++; $display("FAIL early_sync: got %0d expected 2", sync_n - s0); end
    checks++;
    if (valid_n - v0 !== 2) begin errors++; $display("FAIL early_valid: got %0d expected 2", valid_n - v0); end
    // missing edge
    e0 = err_n;
    exp_q.push_back(3'b000);
    drive(1'b1, 100); drive(1'b0, 2100);
    checks++;
    if (err_n - e0 !== 1) begin errors++; $display("FAIL timeout_error: got %0d expected 1", err_n - e0); end
    s0 = sync_n;
    drive(1'b1, 100); drive(1'b0, 800);
    checks++;
    if (sync_n - s0 !== 0) begin errors++; $display("FAIL idle_no_sync: got %0d expected 0", sync_n - s0); end
    v0 = valid_n;
    second(100, 3'b000);
    checks++;
    if (sync_n - s0 !== 1) begin errors++; $display("FAIL relock_sync: got %0d expected 1", sync_n - s0); end
    checks++;
    if (valid_n - v0 !== 1) begin errors++; $display("FAIL relock_valid: got %0d expected 1", valid_n - v0); end
  endtask

  task automatic test_async_reset();
    int s0;
    second(200, 3'b100);
    checks++;
    if (bus.bit_a_o !== 1'b1) begin errors++; $display("FAIL pre_reset_a: got %b expected 1", bus.bit_a_o); end
    drive(1'b1, 150);
    #2 rst_i = 1'b1;
    #1;
    checks++;
    if ({bus.sync_o, bus.bit_a_o, bus.bit_b_o, bus.minute_o, bus.valid_o, bus.error_o} !== 6'b0) begin
      errors++;
      $display("FAIL async_reset: got %b%b%b%b%b%b expected 000000", bus.sync_o, bus.bit_a_o,
               bus.bit_b_o, bus.minute_o, bus.valid_o, bus.error_o);
    end
    repeat (3) step();
    rst_i = 1'b0;
    s0 = sync_n;
    drive(1'b1, 150); drive(1'b0, 200); drive(1'b1, 100); drive(1'b0, 600);
    checks++;
    if (sync_n - s0 !== 0) begin errors++; $display("FAIL post_reset_sync: got %0d expected 0", sync_n - s0); end
    second(100, 3'b000);
    checks++;
    if (sync_n - s0 !== 1) begin errors++; $display("FAIL post_reset_lock: got %0d expected 1", sync_n - s0); end
  endtask

  initial begin
    rst_i = 1'b1;
    bus.data_i = 1'b0;
    test_reset();
    test_basic();
    test_bits();
    test_minute();
    test_glitch();
    test_framing();
    test_async_reset();
    drive(1'b0, 10);
    checks++;
    if (exp_q.size() !== 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending symbols expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
